// File: rtl/doodle_pkg.sv
// doodle_pkg: shared types, segment table and score limits for the doodle score block
package doodle_pkg;
  typedef enum logic {PLAY, OVER} state_e;
  localparam logic [6:0] SEG_LUT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [11:0] SCORE_MAX = 12'h999;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_DASH : SEG_LUT[d];
  endfunction
  function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
    return a[11:8] != b[11:8] ? a[11:8] > b[11:8] :
           a[7:4] != b[7:4]   ? a[7:4] > b[7:4]   : a[3:0] > b[3:0];
  endfunction
endpackage

// File: rtl/doodle_score_if.sv
// doodle_score_if: game-core inputs and score/display outputs of the doodle score block
interface doodle_score_if #(parameter int MAP_W = 6);
  logic             tick_slow;
  logic [MAP_W-1:0] map_move;
  logic             coll_rst;
  logic [2:0]       sel;
  logic [7:0]       seg;
  logic [11:0]      score;
  logic [11:0]      hi_score;
  logic             game_over;
  modport master (output tick_slow, map_move, coll_rst, sel,
                  input  seg, score, hi_score, game_over);
  modport slave  (input  tick_slow, map_move, coll_rst, sel,
                  output seg, score, hi_score, game_over);
endinterface

// File: rtl/doodle_score_bcd3_counter.sv
// bcd3_counter: 3-digit BCD up-counter with sync clear, saturating at 999
module bcd3_counter
  import doodle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] q
);
  logic [11:0] q_d, q_q;
  logic        en, ones_c, tens_c;
  // clear wins; otherwise ripple the BCD carry ones->tens->hundreds unless saturated
  always_comb begin
    en     = inc && q_q != SCORE_MAX;
    ones_c = q_q[3:0] == 4'd9;
    tens_c = ones_c && q_q[7:4] == 4'd9;
    q_d    = clr ? 12'h000 :
             !en ? q_q :
             {tens_c ? q_q[11:8] + 4'd1 : q_q[11:8],
              tens_c ? 4'd0 : ones_c ? q_q[7:4] + 4'd1 : q_q[7:4],
              ones_c ? 4'd0 : q_q[3:0] + 4'd1};
  end
  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= 12'h000;
    else      q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/doodle_score.sv
// doodle_score: climb-row scoring, high score, PLAY/OVER FSM and 7-segment digit drive
module doodle_score
  import doodle_pkg::*;
#(
  parameter int MAP_W     = 6,
  parameter int OVER_HOLD = 32,
  parameter int BLINK_DIV = 3
)(
  input logic            clk,
  input logic            rst,
  doodle_score_if.slave  bus
);
  localparam int HW = $clog2(OVER_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(OVER_HOLD - 1);

  state_e           state_d, state_q;
  logic [MAP_W-1:0] map_q, delta;
  logic             first_q, climb;
  logic [HW-1:0]    hold_d, hold_q;
  logic [BLINK_DIV:0] blink_d, blink_q;
  logic [11:0]      hi_d, hi_q, score;
  logic             game_over_d, game_over_q;
  logic [7:0]       seg_d, seg_q;
  logic             clr, inc;
  logic [15:0]      src;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic             blank;

  bcd3_counter u_score (.clk(clk), .rst(rst), .clr(clr), .inc(inc), .q(score));

  // scroll tracking: the first sample after reset only seeds map_q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map_q   <= '0;
      first_q <= 1'b1;
    end else begin
      map_q   <= bus.map_move;
      first_q <= 1'b0;
    end
  end

  // a forward step of exactly one row (modulo the map width) is a climb
  always_comb begin
    delta = bus.map_move - map_q;
    climb = !first_q && delta == MAP_W'(1);
  end

  // game FSM: collision ends the game and banks the best score, hold timer returns to play
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hi_d        = hi_q;
    blink_d     = bus.tick_slow ? blink_q + 1'b1 : blink_q;
    clr         = 1'b0;
    inc         = 1'b0;
    game_over_d = state_q == OVER;
    if (state_q == PLAY) begin
      if (bus.coll_rst) begin
        state_d = OVER;
        hold_d  = HOLD_INIT;
        blink_d = '0;
        hi_d    = bcd_gt(score, hi_q) ? score : hi_q;
      end else begin
        inc = climb;
      end
    end else if (bus.coll_rst) begin
      hold_d = HOLD_INIT;
    end else if (bus.tick_slow) begin
      state_d = hold_q == '0 ? PLAY : OVER;
      clr     = hold_q == '0;
      hold_d  = hold_q == '0 ? hold_q : hold_q - 1'b1;
    end
  end

  // scan mux and decoder; score digits blink while the game is over
  always_comb begin
    src   = {4'h0, bus.sel < 3'd3 ? score : hi_q};
    idx   = bus.sel < 3'd3 ? bus.sel[1:0] : 2'(bus.sel - 3'd3);
    digit = src[{idx, 2'b00} +: 4];
    blank = bus.sel > 3'd5 || (bus.sel < 3'd3 && state_q == OVER && blink_q[BLINK_DIV]);
    seg_d = blank ? 8'h00 : {bus.sel == 3'd3, seg_of(digit)};
  end

  // state, timers, high score and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PLAY;
      hold_q      <= '0;
      blink_q     <= '0;
      hi_q        <= 12'h000;
      game_over_q <= 1'b0;
      seg_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      hi_q        <= hi_d;
      game_over_q <= game_over_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.score     = score;
  assign bus.hi_score  = hi_q;
  assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_doodle_score.sv
// tb_doodle_score: directed vector table plus hand-written game sequences for doodle_score
module tb_doodle_score;
  logic clk, rst;
  int checks, errors;
  doodle_score_if #(.MAP_W(6)) bus();
  doodle_score dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [5:0]  map;
    logic [2:0]  sel;
    logic [11:0] score;
    logic [7:0]  seg;
  } vec_t;
  vec_t vt [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic climb_n(input int n);
    repeat (n) begin
      bus.map_move = bus.map_move + 6'd1;
      step();
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.tick_slow = 1'b1;
      step();
      bus.tick_slow = 1'b0;
      step();
    end
  endtask

  task automatic collide();
    bus.coll_rst = 1'b1;
    step();
    bus.coll_rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vt[0]  = '{6'd5,  3'd0, 12'h000, 8'h3F};
    vt[1]  = '{6'd6,  3'd0, 12'h001, 8'h3F};
    vt[2]  = '{6'd7,  3'd0, 12'h002, 8'h06};
    vt[3]  = '{6'd7,  3'd0, 12'h002, 8'h5B};
    vt[4]  = '{6'd7,  3'd3, 12'h002, 8'hBF};
    vt[5]  = '{6'd7,  3'd6, 12'h002, 8'h00};
    vt[6]  = '{6'd7,  3'd1, 12'h002, 8'h3F};
    vt[7]  = '{6'd7,  3'd4, 12'h002, 8'h3F};
    vt[8]  = '{6'd62, 3'd2, 12'h002, 8'h3F};
    vt[9]  = '{6'd63, 3'd2, 12'h003, 8'h3F};
    vt[10] = '{6'd0,  3'd2, 12'h004, 8'h3F};
    vt[11] = '{6'd1,  3'd2, 12'h005, 8'h3F};
    vt[12] = '{6'd10, 3'd0, 12'h005, 8'h6D};
    vt[13] = '{6'd20, 3'd0, 12'h005, 8'h6D};
    vt[14] = '{6'd19, 3'd7, 12'h005, 8'h00};
    vt[15] = '{6'd19, 3'd5, 12'h005, 8'h3F};

    rst = 1'b0;
    bus.map_move = 6'd5;
    bus.sel = 3'd7;
    bus.tick_slow = 1'b0;
    bus.coll_rst = 1'b0;
    #12;
    chk("reset_seg", 12'(bus.seg), 12'h000);
    chk("reset_score", bus.score, 12'h000);
    chk("reset_hi", bus.hi_score, 12'h000);
    chk("reset_go", 12'(bus.game_over), 12'h000);
    rst = 1'b1;
    step();
    chk("first_sample_no_event", bus.score, 12'h000);

    for (int i = 0; i < 16; i++) begin
      bus.map_move = vt[i].map;
      bus.sel = vt[i].sel;
      step();
      chk($sformatf("vec%0d_score", i), bus.score, vt[i].score);
      chk($sformatf("vec%0d_seg", i), 12'(bus.seg), 12'(vt[i].seg));
      chk($sformatf("vec%0d_go", i), 12'(bus.game_over), 12'h000);
    end

    climb_n(4);
    chk("pre_tie_score", bus.score, 12'h009);
    bus.map_move = bus.map_move + 6'd1;
    collide();
    chk("tie_hi", bus.hi_score, 12'h009);
    chk("tie_score_dropped", bus.score, 12'h009);
    step();
    chk("tie_go", 12'(bus.game_over), 12'h001);
    climb_n(3);
    chk("over_ignores_climb", bus.score, 12'h009);
    tick_n(10);
    collide();
    tick_n(31);
    chk("reload_still_over", 12'(bus.game_over), 12'h001);
    chk("reload_score_kept", bus.score, 12'h009);
    tick_n(1);
    chk("reload_exit_go", 12'(bus.game_over), 12'h000);
    chk("reload_exit_score", bus.score, 12'h000);
    chk("reload_exit_hi", bus.hi_score, 12'h009);

    climb_n(42);
    chk("game2_score", bus.score, 12'h042);
    bus.sel = 3'd0;
    collide();
    chk("game2_hi", bus.hi_score, 12'h042);
    step();
    chk("game2_go", 12'(bus.game_over), 12'h001);
    for (int k = 1; k <= 32; k++) begin
      tick_n(1);
      if (k < 32) chk($sformatf("blink_k%0d", k), 12'(bus.seg), (k % 16) >= 8 ? 12'h000 : 12'h05B);
    end
    chk("game2_exit_score", bus.score, 12'h000);
    chk("game2_exit_seg", 12'(bus.seg), 12'h03F);
    chk("game2_exit_go", 12'(bus.game_over), 12'h000);

    climb_n(17);
    chk("game3_score", bus.score, 12'h017);
    collide();
    chk("game3_hi_kept", bus.hi_score, 12'h042);
    tick_n(32);
    step();
    chk("game3_exit_score", bus.score, 12'h000);

    climb_n(1002);
    chk("sat_score", bus.score, 12'h999);
    bus.sel = 3'd2;
    step();
    step();
    chk("sat_seg_hundreds", 12'(bus.seg), 12'h06F);
    collide();
    chk("sat_hi", bus.hi_score, 12'h999);
    step();
    chk("sat_over_seg", 12'(bus.seg), 12'h06F);
    chk("sat_over_go", 12'(bus.game_over), 12'h001);

    rst = 1'b0;
    #1;
    chk("async_seg", 12'(bus.seg), 12'h000);
    chk("async_score", bus.score, 12'h000);
    chk("async_hi", bus.hi_score, 12'h000);
    chk("async_go", 12'(bus.game_over), 12'h000);
    #2;
    rst = 1'b1;
    step();
    climb_n(1);
    chk("post_reset_play", bus.score, 12'h001);
    chk("post_reset_go", 12'(bus.game_over), 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
